kf_au_arbiter: RTL and testbench

- Shares the single arithmetic unit (AU) between two requesters: port 0 (sequencer/microcode path) and port 1 (host/diagnostic or a second filter channel).
- Round-robin arbitration; operands are latched at grant and the AU result is returned to the winning requester.
- A watchdog recovers the block if the AU never asserts done.
- Sits between the Router B operand buses and the AU inside the filter top level.

---
 rtl/kf_au_arbiter.sv | 174 +++++++++++++++++
 tb/tb_kf_au_arbiter.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf_au_arbiter.sv
// Round-robin arbiter sharing one arithmetic unit between two requesters,
// with operand latching at grant, result return to the owner and a done watchdog.
module kf_au_arbiter #(
    parameter int unsigned W       = 24,
    parameter int unsigned TOW     = 8,
    parameter int unsigned TIMEOUT = 200
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0,
    input  logic [W-1:0]   r0,
    input  logic [W-1:0]   s0,
    input  logic [W-1:0]   i0,
    input  logic [1:0]     op0,
    input  logic [1:0]     my0,
    output logic           gnt0,
    output logic           done0,
    output logic [W-1:0]   result0,
    input  logic           req1,
    input  logic [W-1:0]   r1,
    input  logic [W-1:0]   s1,
    input  logic [W-1:0]   i1,
    input  logic [1:0]     op1,
    input  logic [1:0]     my1,
    output logic           gnt1,
    output logic           done1,
    output logic [W-1:0]   result1,
    output logic           au_start,
    output logic [W-1:0]   au_r,
    output logic [W-1:0]   au_s,
    output logic [W-1:0]   au_i,
    output logic [1:0]     au_op,
    output logic [1:0]     au_my,
    input  logic           au_done,
    input  logic [W-1:0]   au_result,
    input  logic           au_busy,
    output logic           busy,
    output logic           owner,
    output logic           timeout_err,
    input  logic           clr_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [TOW-1:0] WD_LAST = TOW'(TIMEOUT - 1);

    logic [1:0]     state, state_d;
    logic           last, last_d;
    logic           owner_d;
    logic [TOW-1:0] wd, wd_d;
    logic           gnt0_d, gnt1_d, done0_d, done1_d, start_d, busy_d, err_d;
    logic [W-1:0]   result0_d, result1_d, au_r_d, au_s_d, au_i_d;
    logic [1:0]     au_op_d, au_my_d;
    logic           win;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        last_d    = last;
        owner_d   = owner;
        wd_d      = wd;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        start_d   = 1'b0;
        result0_d = result0;
        result1_d = result1;
        au_r_d    = au_r;
        au_s_d    = au_s;
        au_i_d    = au_i;
        au_op_d   = au_op;
        au_my_d   = au_my;
        err_d     = clr_err ? 1'b0 : timeout_err;
        win       = 1'b0;

        case (state)
            ST_IDLE: begin
                if ((req0 || req1) && !au_busy) begin
                    // On a tie the requester that did not win last time goes next.
                    win     = (req0 && req1) ? ~last : req1;
                    au_r_d  = win ? r1  : r0;
                    au_s_d  = win ? s1  : s0;
                    au_i_d  = win ? i1  : i0;
                    au_op_d = win ? op1 : op0;
                    au_my_d = win ? my1 : my0;
                    owner_d = win;
                    last_d  = win;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (au_done) begin
                    if (owner) begin
                        result1_d = au_result;
                        done1_d   = 1'b1;
                    end else begin
                        result0_d = au_result;
                        done0_d   = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else if (wd == WD_LAST) begin
                    if (owner) begin
                        result1_d = '0;
                        done1_d   = 1'b1;
                    end else begin
                        result0_d = '0;
                        done0_d   = 1'b1;
                    end
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wd_d = wd + TOW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last        <= 1'b1;
            owner       <= 1'b0;
            wd          <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            au_start    <= 1'b0;
            result0     <= '0;
            result1     <= '0;
            au_r        <= '0;
            au_s        <= '0;
            au_i        <= '0;
            au_op       <= '0;
            au_my       <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            last        <= last_d;
            owner       <= owner_d;
            wd          <= wd_d;
            gnt0        <= gnt0_d;
            gnt1        <= gnt1_d;
            done0       <= done0_d;
            done1       <= done1_d;
            au_start    <= start_d;
            result0     <= result0_d;
            result1     <= result1_d;
            au_r        <= au_r_d;
            au_s        <= au_s_d;
            au_i        <= au_i_d;
            au_op       <= au_op_d;
            au_my       <= au_my_d;
            busy        <= busy_d;
            timeout_err <= err_d;
        end
    end

endmodule

// File: tb/tb_kf_au_arbiter.sv
// Self-checking bench for kf_au_arbiter: behavioural AU responder plus a
// transaction-level round-robin reference model.
module tb_kf_au_arbiter;

    localparam int unsigned W       = 24;
    localparam int unsigned TOW     = 8;
    localparam int unsigned TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         req_v [2];
    logic [W-1:0] r_v [2];
    logic [W-1:0] s_v [2];
    logic [W-1:0] i_v [2];
    logic [1:0]   op_v [2];
    logic [1:0]   my_v [2];

    logic         gnt0, gnt1, done0, done1, au_start, busy, owner, timeout_err;
    logic [W-1:0] result0, result1, au_r, au_s, au_i, au_result;
    logic [1:0]   au_op, au_my;
    logic         au_done, au_busy, clr_err;

    logic         au_done_m, au_done_x;
    logic [W-1:0] au_res_m, au_res_x;
    int           au_lat;
    bit           au_hang;

    assign au_done   = au_done_m | au_done_x;
    assign au_result = au_done_x ? au_res_x : au_res_m;

    int nvec = 0;
    int nerr = 0;

    logic         exp_last;
    logic [W-1:0] exp_res [2];

    kf_au_arbiter #(.W(W), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req_v[0]), .r0(r_v[0]), .s0(s_v[0]), .i0(i_v[0]), .op0(op_v[0]), .my0(my_v[0]),
        .gnt0(gnt0), .done0(done0), .result0(result0),
        .req1(req_v[1]), .r1(r_v[1]), .s1(s_v[1]), .i1(i_v[1]), .op1(op_v[1]), .my1(my_v[1]),
        .gnt1(gnt1), .done1(done1), .result1(result1),
        .au_start(au_start), .au_r(au_r), .au_s(au_s), .au_i(au_i), .au_op(au_op), .au_my(au_my),
        .au_done(au_done), .au_result(au_result), .au_busy(au_busy),
        .busy(busy), .owner(owner), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    function automatic logic [W-1:0] au_fn(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return W'(a * b);
            default: return (b == '0) ? '1 : a / b;
        endcase
    endfunction

    // Round-robin rule: single request wins; on a tie the one that did not win last time.
    function automatic logic pick(input logic a, input logic b);
        if (a && b) return ~exp_last;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input int id);
        r_v[id]   = W'($urandom);
        s_v[id]   = W'($urandom);
        i_v[id]   = W'($urandom);
        op_v[id]  = 2'($urandom);
        my_v[id]  = 2'($urandom);
        req_v[id] = 1'b1;
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_gnt"},   32'({gnt0, gnt1}), 32'd0);
        chk({tag, "_done"},  32'({done0, done1}), 32'd0);
        chk({tag, "_start"}, 32'(au_start), 32'd0);
        chk({tag, "_res0"},  32'(result0), 32'd0);
        chk({tag, "_res1"},  32'(result1), 32'd0);
        chk({tag, "_au_r"},  32'(au_r), 32'd0);
        chk({tag, "_au_s"},  32'(au_s), 32'd0);
        chk({tag, "_au_i"},  32'(au_i), 32'd0);
        chk({tag, "_au_opmy"}, 32'({au_op, au_my}), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_owner"}, 32'(owner), 32'd0);
        chk({tag, "_err"},   32'(timeout_err), 32'd0);
    endtask

    task automatic do_reset();
        req_v[0] = 1'b0; req_v[1] = 1'b0;
        clr_err = 1'b0; au_busy = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_zero("reset");
        rst_n = 1'b1;
        exp_last = 1'b1;
        exp_res[0] = '0;
        exp_res[1] = '0;
    endtask

    // One full transaction: grant, operand latch, completion or watchdog abort.
    task automatic serve(input int lat, input bit hang, input bit drop);
        logic         w;
        int           n;
        logic [W-1:0] er;
        w = pick(req_v[0], req_v[1]);
        au_lat = lat;
        au_hang = hang;
        n = 0;
        do begin @(negedge clk); n++; end while (!(gnt0 || gnt1) && n < 50);
        chk("gnt_lat", 32'(n), 32'd1);
        chk("gnt0", 32'(gnt0), 32'(w == 1'b0));
        chk("gnt1", 32'(gnt1), 32'(w == 1'b1));
        chk("start_at_gnt", 32'(au_start), 32'd1);
        chk("owner", 32'(owner), 32'(w));
        chk("busy_issue", 32'(busy), 32'd1);
        chk("au_r", 32'(au_r), 32'(r_v[w]));
        chk("au_s", 32'(au_s), 32'(s_v[w]));
        chk("au_i", 32'(au_i), 32'(i_v[w]));
        chk("au_op", 32'(au_op), 32'(op_v[w]));
        chk("au_my", 32'(au_my), 32'(my_v[w]));
        er = hang ? '0 : au_fn(op_v[w], r_v[w], s_v[w]);
        exp_last = w;
        if (drop) req_v[w] = 1'b0; else arm(int'(w));
        n = 0;
        do begin @(negedge clk); n++; end while (!(done0 || done1) && n < int'(TIMEOUT) + 20);
        chk("done_lat", 32'(n), hang ? 32'(TIMEOUT + 1) : 32'(lat + 1));
        chk("done0", 32'(done0), 32'(w == 1'b0));
        chk("done1", 32'(done1), 32'(w == 1'b1));
        exp_res[w] = er;
        chk("result0", 32'(result0), 32'(exp_res[0]));
        chk("result1", 32'(result1), 32'(exp_res[1]));
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    // Behavioural AU: done with the computed result au_lat cycles after start.
    initial begin
        au_done_m = 1'b0;
        au_res_m = '0;
        forever begin
            @(negedge clk);
            au_done_m = 1'b0;
            if (au_start && !au_hang) begin
                au_res_m = au_fn(au_op, au_r, au_s);
                repeat (au_lat) @(negedge clk);
                au_done_m = 1'b1;
            end
        end
    end

    // Grants and dones are mutually exclusive on every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("gnt_excl", 32'(gnt0 & gnt1), 32'd0);
                chk("done_excl", 32'(done0 & done1), 32'd0);
            end
        end
    end

    initial begin
        int n;
        int pat;
        for (int k = 0; k < 2; k++) begin
            req_v[k] = 1'b0; r_v[k] = '0; s_v[k] = '0; i_v[k] = '0; op_v[k] = '0; my_v[k] = '0;
        end
        au_done_x = 1'b0; au_res_x = '0; au_lat = 3; au_hang = 1'b0;
        au_busy = 1'b0; clr_err = 1'b0;
        do_reset();

        // Single ADD from requester 0.
        r_v[0] = 24'h000400; s_v[0] = 24'h000200; i_v[0] = '0; op_v[0] = 2'd0; my_v[0] = 2'd0;
        req_v[0] = 1'b1;
        serve(3, 1'b0, 1'b1);
        chk("add_result0", 32'(result0), 32'h000600);
        chk("add_result1", 32'(result1), 32'd0);

        // Both held from reset: strict alternation 0,1,0,1.
        do_reset();
        arm(0); arm(1);
        for (int t = 0; t < 4; t++) begin
            chk("alt_order", 32'(pick(req_v[0], req_v[1])), 32'(t % 2));
            serve(int'($urandom_range(1, 8)), 1'b0, 1'b0);
        end
        req_v[0] = 1'b0; req_v[1] = 1'b0;

        // Random request patterns.
        for (int t = 0; t < 12; t++) begin
            pat = int'($urandom_range(1, 3));
            if (pat[0] && !req_v[0]) arm(0);
            if (pat[1] && !req_v[1]) arm(1);
            serve(int'($urandom_range(1, 8)), 1'b0, 1'b1);
        end
        while (req_v[0] || req_v[1]) serve(int'($urandom_range(1, 8)), 1'b0, 1'b1);

        // au_busy blocks the grant until it drops.
        au_busy = 1'b1;
        arm(1);
        repeat (5) begin
            @(negedge clk);
            chk("busy_hold_gnt", 32'({gnt0, gnt1}), 32'd0);
        end
        au_busy = 1'b0;
        serve(2, 1'b0, 1'b1);

        // au_done while idle is ignored.
        au_res_x = 24'hABCDEF; au_done_x = 1'b1;
        @(negedge clk);
        au_done_x = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("idle_done_ign", 32'({done0, done1}), 32'd0);
            chk("idle_res0", 32'(result0), 32'(exp_res[0]));
            chk("idle_res1", 32'(result1), 32'(exp_res[1]));
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Watchdog abort with clr_err held: set wins.
        clr_err = 1'b1;
        arm(0);
        serve(1, 1'b1, 1'b1);
        chk("wd_err_set", 32'(timeout_err), 32'd1);
        clr_err = 1'b0;
        arm(1);
        serve(int'($urandom_range(1, 8)), 1'b0, 1'b1);
        chk("wd_err_sticky", 32'(timeout_err), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("wd_err_clr", 32'(timeout_err), 32'd0);

        // au_done on the terminal watchdog cycle: done wins.
        arm(1);
        serve(int'(TIMEOUT), 1'b0, 1'b1);
        chk("coinc_no_err", 32'(timeout_err), 32'd0);

        // Reset during WAIT; the late au_done must be ignored.
        arm(0);
        au_lat = 10; au_hang = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!gnt0 && n < 50);
        chk("rst_gnt0", 32'(gnt0), 32'd1);
        req_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_idle_zero("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        exp_last = 1'b1; exp_res[0] = '0; exp_res[1] = '0;
        repeat (12) begin
            @(negedge clk);
            chk("rst_no_done", 32'({done0, done1}), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_res", 32'({result0, result1}), 32'd0);
        end
        arm(0); arm(1);
        chk("rst_first_pick", 32'(pick(req_v[0], req_v[1])), 32'd0);
        serve(3, 1'b0, 1'b1);
        serve(3, 1'b0, 1'b1);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
